// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Feeds a small program, held in an internal memory, to a processor one
// instruction at a time. The processor acknowledges each instruction with a
// done pulse. The next instruction is then fetched, until prog_len words
// have completed.
//
// Optional feature macro: SEQ_LOOP_EN. When it is defined, the program
// restarts from address 0 after its last word instead of halting.
//
// Parameters
//   DATA_W      instruction word width
//   ADDR_W      program memory address width (2**ADDR_W words)
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset (program memory is kept)
//   start       launch program from address 0 (only seen in IDLE / HALT)
//   prog_len    number of words to run, captured on start, clamped to 2**ADDR_W
//   wr_en       program memory write strobe (only honoured in IDLE / HALT)
//   wr_addr     program memory write address
//   wr_data     program memory write data
//   done        processor instruction-complete pulse (only seen in WAIT)
//   iin         registered instruction to the processor
//   iin_valid   iin holds an instruction awaiting done
//   pc          address of current / next instruction
//   busy        high in ISSUE and WAIT
//   halted      high in HALT
//   instr_count completed instructions since last start, saturating at 255
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              done,
  output logic [DATA_W-1:0] iin,
  output logic              iin_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        instr_count
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ZERO  = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W:0]     len_s;
  logic [ADDR_W:0]     cap_len_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   iin_s;
  logic                iin_valid_s;
  logic [ADDR_W-1:0]   pc_s;
  logic [7:0]          count_s;
  logic                mem_we_s;
  logic                last_s;

  // Clamp the requested length to the memory depth.
  always_comb begin
    cap_len_s = prog_len;
    if (prog_len > MAX_LEN) begin
      cap_len_s = MAX_LEN;
    end else begin
      cap_len_s = prog_len;
    end
  end

  // Next-state and datapath update decisions.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    iin_s       = iin;
    iin_valid_s = iin_valid;
    pc_s        = pc;
    count_s     = instr_count;
    mem_we_s    = 1'b0;
    // len_r is at least 1 whenever WAIT is reached, so the subtraction cannot wrap there.
    last_s      = ({1'b0, pc} == (len_r - LEN_ONE));

    case (state_r)
      ST_IDLE, ST_HALT: begin
        // Writes are allowed here; a write together with start commits
        // before ISSUE reads memory on the following edge.
        mem_we_s    = wr_en;
        iin_valid_s = 1'b0;
        if (start) begin
          len_s   = cap_len_s;
          pc_s    = PC_ZERO;
          count_s = 8'd0;
          if (cap_len_s == LEN_ZERO) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_ISSUE: begin
        iin_s       = mem_r[pc];
        iin_valid_s = 1'b1;
        state_s     = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          iin_valid_s = 1'b0;
          if (instr_count == 8'd255) begin
            count_s = instr_count;
          end else begin
            count_s = instr_count + 8'd1;
          end
          if (last_s) begin
`ifdef SEQ_LOOP_EN
            pc_s    = PC_ZERO;
            state_s = ST_ISSUE;
`else
            pc_s    = pc;
            state_s = ST_HALT;
`endif
          end else begin
            pc_s    = pc + PC_ONE;
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, outputs and captured length; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      len_r       <= LEN_ZERO;
      iin         <= {DATA_W{1'b0}};
      iin_valid   <= 1'b0;
      pc          <= PC_ZERO;
      instr_count <= 8'd0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      iin         <= iin_s;
      iin_valid   <= iin_valid_s;
      pc          <= pc_s;
      instr_count <= count_s;
      busy        <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
      halted      <= (state_s == ST_HALT);
    end
  end

  // Program memory: no reset so contents survive a sequencer reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench for instr_sequencer. A reference model keeps a copy of
// the program memory. From the sequencing rules, it derives which word each
// instruction slot must show, what pc and instr_count must read, and when
// the block must halt. Compile with +define+SEQ_LOOP_EN for the looping build.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic [DATA_W-1:0] iin;
  logic              iin_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic [7:0]        instr_count;

  instr_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .prog_len(prog_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
    .iin(iin), .iin_valid(iin_valid), .pc(pc), .busy(busy),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];
  int model_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mem_write(input int a, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Reset with every competing input active; a write here must be dropped.
  task automatic do_reset();
    reset   = 1'b1;
    start   = 1'b1;
    done    = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'($urandom);
    wr_data = 16'($urandom);
    step();
    reset = 1'b0; start = 1'b0; done = 1'b0; wr_en = 1'b0;
    model_count = 0;
    chk("rst_iin", iin, 0);
    chk("rst_valid", iin_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
  endtask

  // Run a program with done after 'gap' wait cycles (gap < 0: random).
  task automatic run_prog(input int len, input int gap, input bit wr_with_start, input int extra);
    int eff, nd, idx, g;
    eff = (len > DEPTH) ? DEPTH : len;
`ifdef SEQ_LOOP_EN
    nd = (eff == 0) ? 0 : eff + extra;
`else
    nd = eff;
`endif
    start    = 1'b1;
    prog_len = 5'(len);
    if (wr_with_start) begin
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      wr_data = 16'($urandom);
      model_mem[0] = wr_data;
    end
    step();
    start = 1'b0; wr_en = 1'b0;
    model_count = 0;
    chk("start_valid", iin_valid, 0);
    chk("start_count", instr_count, 0);
    chk("start_pc", pc, 0);
    chk("start_halted", halted, eff == 0);
    chk("start_busy", busy, eff != 0);
    for (int k = 0; k < nd; k++) begin
      idx = k % eff;
      step();
      chk("issue_valid", iin_valid, 1);
      chk("issue_iin", iin, model_mem[idx]);
      chk("issue_pc", pc, idx);
      chk("issue_busy", busy, 1);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int w = 0; w < g; w++) begin
        // Noise while busy: starts and writes must be ignored.
        start    = 1'($urandom);
        prog_len = 5'($urandom);
        wr_en    = 1'b1;
        wr_addr  = 4'($urandom);
        wr_data  = 16'($urandom);
        step();
        chk("wait_iin", iin, model_mem[idx]);
        chk("wait_valid", iin_valid, 1);
      end
      start = 1'b0; wr_en = 1'b0; done = 1'b1;
      step();
      done = 1'b0;
      if (model_count < 255) model_count++;
      chk("done_valid", iin_valid, 0);
      chk("done_count", instr_count, model_count);
`ifdef SEQ_LOOP_EN
      chk("loop_halted", halted, 0);
      chk("loop_busy", busy, 1);
      chk("loop_pc", pc, (idx + 1) % eff);
`else
      if (k == nd - 1) begin
        chk("end_halted", halted, 1);
        chk("end_busy", busy, 0);
        chk("end_pc", pc, eff - 1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("halt_iin_hold", iin, model_mem[eff - 1]);
        chk("halt_count_hold", instr_count, model_count);
      end else begin
        chk("mid_halted", halted, 0);
        chk("mid_pc", pc, idx + 1);
      end
`endif
    end
    if (eff == 0) begin
      for (int w = 0; w < 2; w++) begin
        done = 1'b1;
        step();
        done = 1'b0;
        chk("zero_halted", halted, 1);
        chk("zero_valid", iin_valid, 0);
        chk("zero_count", instr_count, 0);
      end
    end
`ifdef SEQ_LOOP_EN
    if (eff != 0) do_reset();
`endif
  endtask

  // done held high: instructions alternate one WAIT cycle and one ISSUE gap.
  task automatic done_hold(input int n);
    done = 1'b1; start = 1'b1; prog_len = 5'(n);
    step();
    start = 1'b0;
    model_count = 0;
    for (int c = 0; c < 2 * n; c++) begin
      step();
      if (c % 2 == 0) begin
        chk("hold_valid_hi", iin_valid, 1);
        chk("hold_iin", iin, model_mem[c / 2]);
      end else begin
        chk("hold_valid_lo", iin_valid, 0);
        model_count++;
        chk("hold_count", instr_count, model_count);
      end
    end
`ifdef SEQ_LOOP_EN
    chk("hold_halted", halted, 0);
`else
    chk("hold_halted", halted, 1);
`endif
    step();
    chk("hold_count_after", instr_count, model_count);
    done = 1'b0;
`ifdef SEQ_LOOP_EN
    do_reset();
`endif
  endtask

  // Reset in WAIT at pc 2, with a dropped busy write to address 1 first.
  task automatic reset_mid_wait();
    start = 1'b1; prog_len = 5'd4;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      done = 1'b1;
      step();
      done = 1'b0;
    end
    step();
    chk("mid_pc2", pc, 2);
    chk("mid_valid", iin_valid, 1);
    chk("mid_count2", instr_count, 2);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = ~model_mem[1];
    step();
    wr_en = 1'b0;
    do_reset();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; prog_len = 5'd0; wr_en = 1'b0;
    wr_addr = 4'd0; wr_data = 16'd0; done = 1'b0;
    model_count = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'd0;
    do_reset();
    mem_write(0, 16'hB80F);
    mem_write(1, 16'hBCF0);
    mem_write(2, 16'h4370);
    mem_write(3, 16'h8000);
    for (int i = 4; i < DEPTH; i++) mem_write(i, 16'($urandom));
    run_prog(4, 2, 1'b0, 0);
    done_hold(4);
    run_prog(0, -1, 1'b0, 0);
    reset_mid_wait();
    run_prog(4, -1, 1'b0, 0);
    mem_write(1, 16'h1234);
    run_prog(4, -1, 1'b0, 0);
    run_prog(4, -1, 1'b1, 0);
`ifdef SEQ_LOOP_EN
    run_prog(2, 1, 1'b0, 3);
`endif
    run_prog(20, -1, 1'b0, 1);
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) mem_write(int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
      run_prog(int'($urandom_range(0, 20)), -1, 1'($urandom), int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
